// File: rtl/rom_fetch_arbiter.sv
// Two-port round-robin arbiter that turns 32-bit word requests into four sequential
// byte reads of a synchronous-read ROM and returns the big-endian assembled word.
module rom_fetch_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ROM_AW    = 12,
  parameter int unsigned ROM_BYTES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [ADDR_W-1:0] req1_addr_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_err_o,
  output logic              mem_en_o,
  output logic [ROM_AW-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StLast  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       asm_q, asm_d;
  logic              err_q, err_d;
  logic              oor_q, oor_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant0, grant1;
  logic [ADDR_W-1:0] ba;
  logic              ba_in;
  logic [7:0]        cap_byte;
  logic [1:0]        cap_lane;

  assign grant0   = req0_valid_i & (~req1_valid_i | last_grant_q);
  assign grant1   = req1_valid_i & (~req0_valid_i | ~last_grant_q);
  assign ba       = base_q + ADDR_W'(cnt_q);
  assign ba_in    = ba < ADDR_W'(ROM_BYTES);
  assign cap_byte = oor_q ? 8'h00 : mem_data_i;
  // Byte from issue k lands in lane 3-k; cnt_q has already advanced to k+1 (mod 4).
  assign cap_lane = 2'd0 - cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    asm_d        = asm_q;
    err_d        = err_q;
    oor_d        = oor_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    mem_en_o     = 1'b0;
    mem_addr_o   = '0;
    case (state_q)
      StIdle: begin
        req0_ready_o = grant0;
        req1_ready_o = grant1;
        if (grant0 || grant1) begin
          base_d       = grant1 ? req1_addr_i : req0_addr_i;
          owner_d      = grant1;
          last_grant_d = grant1;
          asm_d        = '0;
          err_d        = 1'b0;
          cnt_d        = 2'd0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (cnt_q != 2'd0) begin
          asm_d[{cap_lane, 3'b000} +: 8] = cap_byte;
          err_d = err_q | oor_q;
        end
        mem_en_o   = ba_in;
        mem_addr_o = ba_in ? ba[ROM_AW-1:0] : '0;
        oor_d      = ~ba_in;
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StLast;
      end
      StLast: begin
        asm_d[{cap_lane, 3'b000} +: 8] = cap_byte;
        err_d      = err_q | oor_q;
        rsp_data_d = asm_d;
        rsp_err_d  = err_d;
        state_d    = StResp;
      end
      default: begin
        rsp0_valid_o = ~owner_q;
        rsp1_valid_o = owner_q;
        if (owner_q ? rsp1_ready_i : rsp0_ready_i) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      base_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      asm_q        <= '0;
      err_q        <= 1'b0;
      oor_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      asm_q        <= asm_d;
      err_q        <= err_d;
      oor_q        <= oor_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter: table of single-port reads against a behavioural
// ROM (byte[i] = i[7:0] ^ 0x5A, 0x100..0x103 = 13 05 00 00) plus multi-cycle corner cases.
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data = '0;

  logic [7:0]  rom [4096];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rom_fetch_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_addr_i  (req0_addr),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_addr_i  (req1_addr),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_ready_i (rsp0_ready),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_ready_i (rsp1_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .mem_en_o     (mem_en),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data)
  );

  always @(posedge clk) if (mem_en) mem_data <= rom[mem_addr];

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_req(input logic port, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic exp_err, input string name);
    logic [31:0] ba;
    logic        inr;
    if (port) begin
      req1_valid = 1'b1;
      req1_addr  = addr;
    end else begin
      req0_valid = 1'b1;
      req0_addr  = addr;
    end
    #1;
    chk({name, " ready"}, {30'b0, req1_ready, req0_ready}, port ? 32'd2 : 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ba  = addr + 32'(k);
      inr = ba < 32'd4096;
      chk({name, " mem_en"}, {31'b0, mem_en}, {31'b0, inr});
      chk({name, " mem_addr"}, {20'b0, mem_addr}, inr ? (ba & 32'hFFF) : 32'h0);
      step();
    end
    chk({name, " last quiet"}, {29'b0, mem_en, rsp1_valid, rsp0_valid}, 32'h0);
    step();
    chk({name, " rsp valid"}, {30'b0, rsp1_valid, rsp0_valid}, port ? 32'd2 : 32'd1);
    chk({name, " rsp data"}, rsp_data, exp_data);
    chk({name, " rsp err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    if (port) rsp1_ready = 1'b1;
    else rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk({name, " rsp drop"}, {30'b0, rsp1_valid, rsp0_valid}, 32'h0);
    chk({name, " data hold"}, rsp_data, exp_data);
  endtask

  // Waits (bounded) for the given port's response valid; false if it never came.
  task automatic wait_rsp(input logic port, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 12 && !ok; c++) begin
      if (port ? rsp1_valid : rsp0_valid) ok = 1'b1;
      else step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ok;
    logic       g[4];
    int         ng;
    logic       seen;

    for (int i = 0; i < 4096; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom[12'h100] = 8'h13;
    rom[12'h101] = 8'h05;
    rom[12'h102] = 8'h00;
    rom[12'h103] = 8'h00;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h1305_0000, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h4A4B_4849, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0FFE, 32'hA4A5_0000, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFE, 32'h0000_5A5B, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h5A5B_5859, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0203, 32'h595E_5F5C, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0FFD, 32'hA7A4_A500, 1'b1};

    do_reset();
    chk("reset outputs", {26'b0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, rsp_err},
        32'h0);
    chk("reset data", rsp_data, 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Contention: both ports valid continuously, grants must alternate starting with port 0.
    do_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_addr  = 32'h0;
    req1_addr  = 32'h10;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    ng = 0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      if (req0_ready | req1_ready) begin
        g[ng] = req1_ready;
        ng++;
      end
      if (rsp0_valid | rsp1_valid) begin
        chk("cont rsp exclusive", {31'b0, rsp0_valid & rsp1_valid}, 32'h0);
        chk("cont rsp data", rsp_data, rsp1_valid ? 32'h4A4B_4849 : 32'h5A5B_5859);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("cont grant count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont grant%0d", i), {31'b0, g[i]}, 32'(i % 2));
    wait_rsp(1'b1, ok);
    chk("cont last rsp seen", {31'b0, ok}, 32'h1);
    chk("cont last rsp data", rsp_data, 32'h4A4B_4849);
    chk("cont last rsp excl", {31'b0, rsp0_valid}, 32'h0);
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Backpressure: port 0 response held, port 1 waits.
    req0_valid = 1'b1;
    req0_addr  = 32'h100;
    #1;
    step();
    req0_valid = 1'b0;
    wait_rsp(1'b0, ok);
    chk("bp rsp seen", {31'b0, ok}, 32'h1);
    req1_valid = 1'b1;
    req1_addr  = 32'h10;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("bp hold", {28'b0, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 32'h8);
      chk("bp data", rsp_data, 32'h1305_0000);
      chk("bp err", {31'b0, rsp_err}, 32'h0);
      step();
    end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    chk("bp release", {30'b0, rsp0_valid, req1_ready}, 32'h1);
    step();
    req1_valid = 1'b0;
    wait_rsp(1'b1, ok);
    chk("bp port1 rsp", {31'b0, ok}, 32'h1);
    chk("bp port1 data", rsp_data, 32'h4A4B_4849);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;

    // Reset mid-ISSUE: port 0 accepted, reset at T+2 aborts and restores port 0 tie priority.
    req0_valid = 1'b1;
    req0_addr  = 32'h100;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst mid outputs", {26'b0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_en, rsp_err},
        32'h0);
    chk("rst mid mem_addr", {20'b0, mem_addr}, 32'h0);
    chk("rst mid data", rsp_data, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen |= rsp0_valid | rsp1_valid | mem_en;
      step();
    end
    chk("rst mid no rsp", {31'b0, seen}, 32'h0);
    req0_valid = 1'b1;
    req0_addr  = 32'h0;
    req1_valid = 1'b1;
    req1_addr  = 32'h10;
    #1;
    chk("rst mid tie", {30'b0, req1_ready, req0_ready}, 32'h1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares one byte-wide, synchronous-read instruction ROM port between two 32-bit word requesters: port 0 is the IFU and port 1 is the LSU/debug loader.
- Each accepted request is sequenced into four byte reads at consecutive addresses. The bytes are assembled into one 32-bit word and returned over a valid/ready response channel.
- Sits between the fetch/load units and the ROM macro, replacing direct combinational word indexing.

Parameters:
- ADDR_W, 32, request address width.
- ROM_AW, 12, ROM byte-address width.
- ROM_BYTES, 4096, number of implemented ROM bytes; byte addresses >= ROM_BYTES are out of range.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 request accepted.
- req0_addr_i  in  ADDR_W  port 0 word base byte address.
- req1_valid_i  in  1  port 1 request valid.
- req1_ready_o  out  1  port 1 request accepted.
- req1_addr_i  in  ADDR_W  port 1 word base byte address.
- rsp0_valid_o  out  1  port 0 response valid.
- rsp0_ready_i  in  1  port 0 response taken.
- rsp1_valid_o  out  1  port 1 response valid.
- rsp1_ready_i  in  1  port 1 response taken.
- rsp_data_o  out  32  assembled word, shared by both ports.
- rsp_err_o  out  1  at least one byte of the word was out of range.
- mem_en_o  out  1  ROM read enable.
- mem_addr_o  out  ROM_AW  ROM byte address.
- mem_data_i  in  8  ROM read data, valid the cycle after mem_en_o.

Behaviour:
- States:
  - IDLE: arbitrate incoming requests.
  - ISSUE: byte counter cnt steps 0..3.
  - LAST: capture the final byte.
  - RESP: hold the response until taken.
- Reset (synchronous):
  - State goes to IDLE; cnt, data register and err are cleared to 0.
  - All ready, valid and mem_en outputs are 0; last_grant is 1, so port 0 wins the first tie.
  - Reset during any state aborts the transaction; no response is produced.
- IDLE arbitration:
  - reqN_ready_o is combinational and high only in IDLE, for the winner only.
  - If only one port is valid, that port wins.
  - If both are valid, the port not equal to last_grant wins (round-robin).
- Acceptance (cycle T, valid&ready):
  - Latch base = addr and owner = winner; set last_grant = owner.
  - Clear the data register and err; go to ISSUE with cnt = 0.
- ISSUE (cycles T+1..T+4):
  - Byte address ba = base + cnt, computed modulo 2^ADDR_W.
  - If ba < ROM_BYTES: mem_en_o = 1 and mem_addr_o = ba[ROM_AW-1:0].
  - Otherwise: mem_en_o = 0, mem_addr_o = 0, and the slot is marked out of range.
  - Going to LAST is triggered after cnt = 3.
- Capture (cycles T+2..T+5):
  - Each cycle after an issue, mem_data_i (or 0x00 for an out-of-range slot) is written into byte lane 3-k for issue k.
  - The lowest address lands in bits [31:24] (big-endian assembly, identical to existing fetch word format).
  - err is ORed with the out-of-range flag of each slot.
  - The byte from the cnt = 3 issue is captured in LAST.
- RESP (from cycle T+6):
  - rspN_valid_o = 1 for the owner only, with rsp_data_o and rsp_err_o stable.
  - Held until rspN_ready_i, then go to IDLE. The earliest next accept is the following cycle.
  - Minimum request-to-response latency is 6 cycles; peak throughput is one word per 7 cycles.
- rsp_data_o and rsp_err_o hold their last values outside RESP.
- The non-owner port's request waits with ready low; its request must be held until accepted.
- Requester rules: a requester must not drop valid or change addr before ready. Behaviour on violation is unspecified but must not hang the FSM.
- mem_en_o is 0 in IDLE, LAST and RESP.

Test Plan:
- Aligned read: ROM bytes 0x100..0x103 = 13 05 00 00; port 0 reads 0x100 at T -> mem_addr_o = 0x100..0x103 in T+1..T+4; rsp0_valid_o at T+6 with data 0x13050000, err 0.
- Contention: both ports valid continuously after reset, addresses 0x0 and 0x10 -> grants alternate 0, 1, 0, 1; each response is seen only on its owner's rsp valid.
- Out of range: port 1 reads 0xFFE with ROM_BYTES = 4096 -> two enables (0xFFE, 0xFFF) and two disabled slots; data = {b[FFE], b[FFF], 00, 00}, err = 1.
- Backpressure: hold rsp0_ready_i low for 10 cycles -> valid and data stay stable, no new accept occurs, and port 1 ready stays low; release -> IDLE next cycle.
- Reset mid-ISSUE: assert rst_i at T+2 -> next cycle all outputs are 0, state is IDLE, no response appears, and port 0 wins the next tie.
- Misaligned address wrap: port 0 reads 0xFFFFFFFE -> byte addresses wrap to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; the first two slots are out of range, so err = 1 and lanes [31:16] = 0.
